// File: rtl/filtr_wejsc.sv
// Input conditioning for 64 PLC inputs: two-flop synchroniser, shared prescaled sample tick,
// per-bit debounce counter and a registered change pulse for the input image register.
module filtr_wejsc #(
  parameter int unsigned PRESC  = 1000,
  parameter int unsigned STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [7:0] out4,
  output logic [7:0] out5,
  output logic [7:0] out6,
  output logic [7:0] out7,
  output logic       zmiana
);

  localparam int unsigned NumBits = 64;
  localparam logic [15:0] PLast   = 16'(PRESC - 1);
  localparam logic [3:0]  CLast   = 4'(STABLE - 1);

  logic [NumBits-1:0] raw;
  logic [NumBits-1:0] s1_q, s2_q;
  logic [NumBits-1:0] out_q, out_d;
  logic [15:0]        p_q, p_d;
  logic [3:0]         c_q [NumBits];
  logic [3:0]         c_d [NumBits];
  logic               tick;
  logic               zmiana_q, zmiana_d;

  // Bit i of inN maps to flat bit N*8+i.
  assign raw = {in7, in6, in5, in4, in3, in2, in1, in0};

  assign tick = (p_q == PLast);

  always_comb begin
    p_d = p_q + 16'd1;
    if (tick) begin
      p_d = '0;
    end
  end

  always_comb begin
    out_d    = out_q;
    zmiana_d = 1'b0;
    for (int i = 0; i < NumBits; i++) begin
      c_d[i] = c_q[i];
      if (tick) begin
        if (s2_q[i] == out_q[i]) begin
          // Level matches the output again: any partial count is a bounce.
          c_d[i] = '0;
        end else if (c_q[i] == CLast) begin
          out_d[i] = s2_q[i];
          c_d[i]   = '0;
          zmiana_d = 1'b1;
        end else begin
          c_d[i] = c_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      p_q      <= '0;
      out_q    <= '0;
      zmiana_q <= 1'b0;
      for (int i = 0; i < NumBits; i++) begin
        c_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      p_q      <= p_d;
      out_q    <= out_d;
      zmiana_q <= zmiana_d;
      for (int i = 0; i < NumBits; i++) begin
        c_q[i] <= c_d[i];
      end
    end
  end

  assign out0   = out_q[7:0];
  assign out1   = out_q[15:8];
  assign out2   = out_q[23:16];
  assign out3   = out_q[31:24];
  assign out4   = out_q[39:32];
  assign out5   = out_q[47:40];
  assign out6   = out_q[55:48];
  assign out7   = out_q[63:56];
  assign zmiana = zmiana_q;

endmodule
